// File: rtl/data_mem_responder_if.sv
// Load/store bus between the core's data port and the data-memory responder.
// The master drives the strobes, address and store data; the slave returns load data and a ready/error pulse.
interface data_mem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] dAddress;
  logic [31:0] dWriteData;
  logic [31:0] dReadData;
  logic        dReady;
  logic        dError;

  modport master (
    output MemRead, MemWrite, dAddress, dWriteData,
    input  dReadData, dReady, dError
  );

  modport slave (
    input  MemRead, MemWrite, dAddress, dWriteData,
    output dReadData, dReady, dError
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data RAM answering the core's load/store strobes after WAIT_CYCLES wait states.
// Optional access counters are built in when DMEM_ACCESS_STATS_EN is defined.
module data_mem_responder #(
  parameter int          DATA_DEPTH  = 256,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  data_mem_responder_if.slave   bus,
  output logic                  busy_o,
  output logic [15:0]           rd_count_o,
  output logic [15:0]           wr_count_o
);
  localparam int AW = $clog2(DATA_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q;
  logic [3:0]      wait_q;
  logic            req_wr_q;
  logic            req_err_q;
  logic [AW-1:0]   req_idx_q;
  logic [31:0]     req_wdata_q;
  logic [31:0]     rdata_q;
  logic            ready_q;
  logic            err_q;
  logic [31:0]     mem_q [DATA_DEPTH];

  logic            strobe;
  logic [31:0]     off;
  logic            live_err;
  logic            acc_go;
  logic            acc_wr;
  logic            acc_err;
  logic [AW-1:0]   acc_idx;
  logic [31:0]     acc_wdata;

  assign strobe   = bus.MemRead | bus.MemWrite;
  assign off      = bus.dAddress - ADDR_BASE;
  // ADDR_BASE is word-aligned, so off[1:0] equals the address alignment bits.
  assign live_err = (off[1:0] != 2'b00) | (|off[31:AW+2]) | (bus.MemRead & bus.MemWrite);

  // With no wait states the access happens on the capture edge, so use the live request.
  always_comb begin
    acc_go    = 1'b0;
    acc_wr    = req_wr_q;
    acc_err   = req_err_q;
    acc_idx   = req_idx_q;
    acc_wdata = req_wdata_q;
    if (state_q == IDLE) begin
      acc_go    = strobe && (WAIT_CYCLES == 0);
      acc_wr    = bus.MemWrite;
      acc_err   = live_err;
      acc_idx   = off[AW+1:2];
      acc_wdata = bus.dWriteData;
    end else if (state_q == WAIT) begin
      acc_go    = (wait_q == 4'd0);
    end
  end

`ifdef DMEM_ACCESS_STATS_EN
  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;
  assign rd_count_o = rd_cnt_q;
  assign wr_count_o = wr_cnt_q;
`else
  assign rd_count_o = 16'd0;
  assign wr_count_o = 16'd0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wait_q      <= 4'd0;
      req_wr_q    <= 1'b0;
      req_err_q   <= 1'b0;
      req_idx_q   <= '0;
      req_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < DATA_DEPTH; i++) mem_q[i] <= 32'd0;
`ifdef DMEM_ACCESS_STATS_EN
      rd_cnt_q    <= 16'd0;
      wr_cnt_q    <= 16'd0;
`endif
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: if (strobe) begin
          req_wr_q    <= bus.MemWrite;
          req_err_q   <= live_err;
          req_idx_q   <= off[AW+1:2];
          req_wdata_q <= bus.dWriteData;
          if (WAIT_CYCLES > 0) begin
            state_q <= WAIT;
            wait_q  <= 4'(WAIT_CYCLES - 1);
          end else begin
            state_q <= RESP;
          end
        end
        WAIT: if (wait_q == 4'd0) state_q <= RESP;
              else                wait_q  <= wait_q - 4'd1;
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (acc_go) begin
        ready_q <= 1'b1;
        err_q   <= acc_err;
        if (!acc_err) begin
          if (acc_wr) begin
            mem_q[acc_idx] <= acc_wdata;
`ifdef DMEM_ACCESS_STATS_EN
            if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
`endif
          end else begin
            rdata_q <= mem_q[acc_idx];
`ifdef DMEM_ACCESS_STATS_EN
            if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
`endif
          end
        end
      end
    end
  end

  assign bus.dReadData = rdata_q;
  assign bus.dReady    = ready_q;
  assign bus.dError    = err_q;
  assign busy_o        = (state_q != IDLE);
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances (no wait, 3 wait states, offset base)
// checked against a shadow RAM model through an expected-response queue.
module tb_data_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [3];
  logic        mr   [3];
  logic        mw   [3];
  logic [31:0] ad   [3];
  logic [31:0] wd   [3];
  logic [31:0] rdo  [3];
  logic        rdy  [3];
  logic        erro [3];
  logic        busy [3];
  logic [15:0] rcnt [3];
  logic [15:0] wcnt [3];

  data_mem_responder_if bus0 ();
  data_mem_responder_if bus1 ();
  data_mem_responder_if bus2 ();

  assign bus0.MemRead = mr[0]; assign bus0.MemWrite = mw[0];
  assign bus0.dAddress = ad[0]; assign bus0.dWriteData = wd[0];
  assign bus1.MemRead = mr[1]; assign bus1.MemWrite = mw[1];
  assign bus1.dAddress = ad[1]; assign bus1.dWriteData = wd[1];
  assign bus2.MemRead = mr[2]; assign bus2.MemWrite = mw[2];
  assign bus2.dAddress = ad[2]; assign bus2.dWriteData = wd[2];
  assign rdo[0] = bus0.dReadData; assign rdy[0] = bus0.dReady; assign erro[0] = bus0.dError;
  assign rdo[1] = bus1.dReadData; assign rdy[1] = bus1.dReady; assign erro[1] = bus1.dError;
  assign rdo[2] = bus2.dReadData; assign rdy[2] = bus2.dReady; assign erro[2] = bus2.dError;

  logic b0, b1, b2;
  logic [15:0] rc0, rc1, rc2, wc0, wc1, wc2;
  assign busy[0] = b0; assign busy[1] = b1; assign busy[2] = b2;
  assign rcnt[0] = rc0; assign rcnt[1] = rc1; assign rcnt[2] = rc2;
  assign wcnt[0] = wc0; assign wcnt[1] = wc1; assign wcnt[2] = wc2;

  data_mem_responder #(.DATA_DEPTH(256), .ADDR_BASE(32'h0000_0000), .WAIT_CYCLES(0)) u_w0 (
    .clk_i(clk), .rst_i(rst[0]), .bus(bus0), .busy_o(b0), .rd_count_o(rc0), .wr_count_o(wc0));
  data_mem_responder #(.DATA_DEPTH(256), .ADDR_BASE(32'h0000_0000), .WAIT_CYCLES(3)) u_w3 (
    .clk_i(clk), .rst_i(rst[1]), .bus(bus1), .busy_o(b1), .rd_count_o(rc1), .wr_count_o(wc1));
  data_mem_responder #(.DATA_DEPTH(256), .ADDR_BASE(32'h0000_1000), .WAIT_CYCLES(0)) u_base (
    .clk_i(clk), .rst_i(rst[2]), .bus(bus2), .busy_o(b2), .rd_count_o(rc2), .wr_count_o(wc2));

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] shadow  [3][256];
  logic [31:0] m_rdata [3];
  int          m_rd [3];
  int          m_wr [3];
  int          waits [3] = '{0, 3, 0};
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(int d);
    for (int i = 0; i < 256; i++) shadow[d][i] = 32'd0;
    m_rdata[d] = 32'd0;
    m_rd[d] = 0;
    m_wr[d] = 0;
  endtask

  task automatic chk_cnt(int d);
`ifdef DMEM_ACCESS_STATS_EN
    chk("rd_count", 32'(rcnt[d]), 32'(m_rd[d]));
    chk("wr_count", 32'(wcnt[d]), 32'(m_wr[d]));
`else
    chk("rd_count", 32'(rcnt[d]), 32'd0);
    chk("wr_count", 32'(wcnt[d]), 32'd0);
`endif
  endtask

  // One request: model the expected response, drive the strobe for one edge, then wait for dReady.
  task automatic req(int d, bit rd, bit wr, logic [31:0] a, logic [31:0] wdat, bit poke);
    exp_t        e;
    logic [31:0] base;
    logic [31:0] off;
    bit          er;
    int          n;
    int          bc;
    base = (d == 2) ? 32'h0000_1000 : 32'h0000_0000;
    off  = a - base;
    er   = (a[1:0] != 2'b00) || (off >= 32'd1024) || (rd && wr);
    if (!er) begin
      if (wr) begin shadow[d][off[9:2]] = wdat; m_wr[d]++; end
      else    begin m_rdata[d] = shadow[d][off[9:2]]; m_rd[d]++; end
    end
    e.err  = er;
    e.data = m_rdata[d];
    sb.push_back(e);
    @(negedge clk);
    mr[d] = rd; mw[d] = wr; ad[d] = a; wd[d] = wdat;
    @(posedge clk); #1;
    mr[d] = poke; mw[d] = 1'b0; ad[d] = $urandom; wd[d] = $urandom;
    n = 0; bc = 0;
    while (!rdy[d] && n < 40) begin
      if (busy[d]) bc++;
      @(posedge clk); #1;
      mr[d] = 1'b0;
      n++;
    end
    if (busy[d]) bc++;
    chk("latency", 32'(n), 32'(waits[d]));
    chk("busy_cycles", 32'(bc), 32'(waits[d] + 1));
    e = sb.pop_front();
    chk("dError", 32'(erro[d]), 32'(e.err));
    chk("dReadData", rdo[d], e.data);
    @(posedge clk); #1;
    chk("dReady_width", 32'(rdy[d]), 32'd0);
  endtask

  task automatic no_ready(int d, int cycles, string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (rdy[d]) seen++;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; mr[d] = 1'b0; mw[d] = 1'b0; ad[d] = 32'd0; wd[d] = 32'd0;
      model_reset(d);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk("rst_dReadData", rdo[d], 32'd0);
      chk("rst_dReady", 32'(rdy[d]), 32'd0);
      chk("rst_dError", 32'(erro[d]), 32'd0);
      chk("rst_busy", 32'(busy[d]), 32'd0);
      chk_cnt(d);
    end

    // Zero wait states: basic write/read, error cases, boundary word
    req(0, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    req(0, 1, 0, 32'h0000_0010, 32'h0, 0);
    req(0, 1, 0, 32'h0000_0012, 32'h0, 0);
    req(0, 0, 1, 32'h0000_0400, 32'h1234_5678, 0);
    req(0, 1, 1, 32'h0000_0010, 32'h5555_5555, 0);
    req(0, 1, 0, 32'h0000_0010, 32'h0, 0);
    req(0, 0, 1, 32'h0000_03FC, 32'hA5A5_0001, 0);
    req(0, 1, 0, 32'h0000_03FC, 32'h0, 0);
    req(0, 1, 0, 32'h0000_0000, 32'h0, 0);
    chk_cnt(0);

    // Three wait states, with a strobe poked during WAIT that must be ignored
    req(1, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    req(1, 1, 0, 32'h0000_0010, 32'h0, 1);
    no_ready(1, 6, "ignored_strobe");
    chk("after_poke_busy", 32'(busy[1]), 32'd0);
    chk_cnt(1);

    // Reset during WAIT aborts the write
    @(negedge clk);
    mw[1] = 1'b1; ad[1] = 32'h0000_0040; wd[1] = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mw[1] = 1'b0;
    @(posedge clk); #1;
    chk("midreq_busy", 32'(busy[1]), 32'd1);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    model_reset(1);
    chk("midreq_dReadData", rdo[1], 32'd0);
    chk("midreq_busy_after", 32'(busy[1]), 32'd0);
    chk("midreq_dError", 32'(erro[1]), 32'd0);
    no_ready(1, 6, "midreq_no_ready");
    chk_cnt(1);
    req(1, 1, 0, 32'h0000_0040, 32'h0, 0);

    // Non-zero base: below-base wraps to an error, top word legal, one past is not
    req(2, 1, 0, 32'h0000_0FFC, 32'h0, 0);
    req(2, 0, 1, 32'h0000_1000, 32'h0BAD_F00D, 0);
    req(2, 0, 1, 32'h0000_13FC, 32'h7777_1111, 0);
    req(2, 1, 0, 32'h0000_13FC, 32'h0, 0);
    req(2, 1, 0, 32'h0000_1400, 32'h0, 0);
    req(2, 1, 0, 32'h0000_1000, 32'h0, 0);
    chk_cnt(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
